// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the frequency meter.
package freq_meter_pkg;

   typedef enum logic {
      ARM     = 1'b0,
      MEASURE = 1'b1
   } state_t;

   localparam int unsigned CLK_HZ          = 24_000_000;
   localparam int unsigned DEF_CNT_W       = 32;
   localparam int unsigned DEF_AVG_LOG2    = 2;
   // 100 ms of silence at the system clock rate
   localparam int unsigned DEF_TIMEOUT_CYC = CLK_HZ / 10;
   localparam int unsigned DEF_MIN_PERIOD  = 64;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin, followed by a registered
// rising-edge pulse. A rise on sig_in shows up as a one-cycle pulse three
// clocks later.
module freq_meter_edge_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic sig_in,
   output logic rise_pulse
);

   logic sync_1;
   logic sync_2;
   logic sync_d;

   // synchronizer chain, history flop and registered edge detect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         sync_d     <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         sync_1     <= sig_in;
         sync_2     <= sync_1;
         sync_d     <= sync_2;
         rise_pulse <= sync_2 & ~sync_d;
      end
   end

endmodule

// File: rtl/freq_meter.sv
// Period meter: timestamps synchronized rising edges of sig_in, averages
// 2**AVG_LOG2 edge-to-edge periods and reports the floor of the mean with a
// one-cycle strobe. signal_lost is high until a full average has been
// reported, and again after a timeout or a clear.
//
// Build option: FREQ_METER_GLITCH_EN -- when defined, edges arriving less
// than MIN_PERIOD cycles after the last accepted edge are ignored while
// measuring. When undefined every edge is taken.
//
// state   | meaning
// ARM     | waiting for a first edge to start timing; no timeout
// MEASURE | counting cycles since the last accepted edge, accumulating
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sig_in,
   input  logic             clear,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             signal_lost
);

   localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
   localparam int unsigned NS_W  = AVG_LOG2 + 1;

`ifdef FREQ_METER_GLITCH_EN
   localparam bit GLITCH_EN = 1'b1;
`else
   localparam bit GLITCH_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_PERIOD);
   localparam logic [NS_W-1:0]  LAST_SAMP   = NS_W'((1 << AVG_LOG2) - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [ACC_W-1:0]   acc;
   logic [NS_W-1:0]    nsamp;
   logic               rise_pulse;
   logic               accept;
   logic [ACC_W-1:0]   acc_sum;

   freq_meter_edge_sync u_edge_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .sig_in     (sig_in),
      .rise_pulse (rise_pulse)
   );

   // cnt holds the exact distance to the last accepted edge, so it is the sample
   assign accept  = rise_pulse && (!GLITCH_EN || (cnt >= MIN_CNT));
   assign acc_sum = acc + ACC_W'(cnt);

   // measurement FSM, accumulator and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ARM;
         cnt          <= '0;
         acc          <= '0;
         nsamp        <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         signal_lost  <= 1'b1;
      end else begin
         period_valid <= 1'b0;
         if (clear) begin
            state       <= ARM;
            cnt         <= '0;
            acc         <= '0;
            nsamp       <= '0;
            signal_lost <= 1'b1;
         end else begin
            case (state)
               ARM: begin
                  if (rise_pulse) begin
                     state <= MEASURE;
                     cnt   <= CNT_W'(1);
                  end
               end
               MEASURE: begin
                  if (accept) begin
                     cnt <= CNT_W'(1);
                     if (nsamp == LAST_SAMP) begin
                        period       <= CNT_W'(acc_sum >> AVG_LOG2);
                        period_valid <= 1'b1;
                        signal_lost  <= 1'b0;
                        acc          <= '0;
                        nsamp        <= '0;
                     end else begin
                        acc   <= acc_sum;
                        nsamp <= nsamp + NS_W'(1);
                     end
                  end else if (cnt == TIMEOUT_CNT) begin
                     state       <= ARM;
                     cnt         <= '0;
                     acc         <= '0;
                     nsamp       <= '0;
                     signal_lost <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter. Runs with shortened timeout so the
// whole sequence stays short; waveform periods are scaled to match.
module tb_freq_meter;

   localparam int AVG  = 2;
   localparam int NAVG = 1 << AVG;
   localparam int TO   = 2500;
   localparam int MINP = 64;
`ifdef FREQ_METER_GLITCH_EN
   localparam bit GL = 1'b1;
`else
   localparam bit GL = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        sig_in;
   logic        clear;
   logic [31:0] period;
   logic        period_valid;
   logic        signal_lost;

   freq_meter #(
      .CNT_W       (32),
      .AVG_LOG2    (AVG),
      .TIMEOUT_CYC (TO),
      .MIN_PERIOD  (MINP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sig_in       (sig_in),
      .clear        (clear),
      .period       (period),
      .period_valid (period_valid),
      .signal_lost  (signal_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stimulus -> model event queues (clock index at which the DUT sees them)
   int rise_q[$];
   int clr_q[$];
   int last_rise = 0;

   // behavioural model: timestamps of accepted edges, plain arithmetic
   bit          m_arm    = 1'b1;
   int          m_last   = 0;
   longint      m_sum    = 0;
   int          m_n      = 0;
   longint      m_period = 0;
   bit          m_valid  = 1'b0;
   bit          m_lost   = 1'b1;
   bit          ev_edge;
   bit          ev_clr;
   int          el;

   always @(negedge clk) begin
      if (!reset_n) begin
         m_arm = 1'b1; m_sum = 0; m_n = 0; m_period = 0;
         m_valid = 1'b0; m_lost = 1'b1;
         rise_q.delete(); clr_q.delete();
      end else begin
         ev_edge = 1'b0;
         ev_clr  = 1'b0;
         while (rise_q.size() > 0 && rise_q[0] + 4 < cyc) void'(rise_q.pop_front());
         if (rise_q.size() > 0 && rise_q[0] + 4 == cyc) begin
            ev_edge = 1'b1;
            void'(rise_q.pop_front());
         end
         while (clr_q.size() > 0 && clr_q[0] < cyc) void'(clr_q.pop_front());
         if (clr_q.size() > 0 && clr_q[0] == cyc) begin
            ev_clr = 1'b1;
            void'(clr_q.pop_front());
         end
         m_valid = 1'b0;
         if (ev_clr) begin
            m_arm = 1'b1; m_sum = 0; m_n = 0; m_lost = 1'b1;
         end else if (m_arm) begin
            if (ev_edge) begin
               m_arm  = 1'b0;
               m_last = cyc;
            end
         end else begin
            el = cyc - m_last;
            if (ev_edge && (!GL || el >= MINP)) begin
               m_sum  = m_sum + el;
               m_n    = m_n + 1;
               m_last = cyc;
               if (m_n == NAVG) begin
                  m_period = m_sum / NAVG;
                  m_valid  = 1'b1;
                  m_lost   = 1'b0;
                  m_sum    = 0;
                  m_n      = 0;
               end
            end else if (el == TO) begin
               m_arm = 1'b1; m_lost = 1'b1; m_sum = 0; m_n = 0;
            end
         end
      end
      checks++;
      if (period !== m_period[31:0] || period_valid !== m_valid || signal_lost !== m_lost) begin
         failures++;
         $display("FAIL cycle_cmp cyc=%0d period=%0d exp=%0d valid=%0b exp=%0b lost=%0b exp=%0b",
                  cyc, period, m_period, period_valid, m_valid, signal_lost, m_lost);
      end
   end

   // strobe count and signal_lost rise time
   int strobes       = 0;
   int lost_rise_cyc = -1;
   bit lost_d        = 1'b0;
   always @(negedge clk) begin
      if (period_valid) strobes++;
      if (signal_lost && !lost_d) lost_rise_cyc = cyc;
      lost_d = signal_lost;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rise_now();
      sig_in = 1'b1;
      rise_q.push_back(cyc);
      last_rise = cyc;
   endtask

   task automatic first_rise();
      sig_in = 1'b0;
      tick(5);
      rise_now();
   endtask

   // next rise exactly p cycles after the previous one, 50% duty
   task automatic gap(input int p);
      tick(last_rise + p / 2 - cyc);
      sig_in = 1'b0;
      tick(last_rise + p - cyc);
      rise_now();
   endtask

   int sc;

   initial begin
      reset_n = 1'b0;
      sig_in  = 1'b0;
      clear   = 1'b0;
      tick(3);
      #2 reset_n = 1'b1;
      tick(2);
      chk("reset_period", period, 0);
      chk("reset_valid", period_valid, 0);
      chk("reset_lost", signal_lost, 1);

      // lock onto a 1530-cycle square wave: strobe after the 5th rise
      first_rise();
      for (int i = 0; i < 3; i++) gap(1530);
      tick(8);
      chk("lock_no_early_strobe", strobes, 0);
      gap(1530);
      tick(3);
      chk("lock_strobe_pending", strobes, 0);
      chk("lock_lost_before", signal_lost, 1);
      tick(2);
      chk("lock_strobes", strobes, 1);
      chk("lock_period", period, 1530);
      chk("lock_lost_after", signal_lost, 0);

      // short pulse right after the window-starting rise (extra rise 20 cycles in)
      tick(last_rise + 10 - cyc);
      sig_in = 1'b0;
      tick(last_rise + 20 - cyc);
      sig_in = 1'b1;
      rise_q.push_back(cyc);
      gap(1530);
      for (int i = 0; i < 3; i++) gap(1530);
      tick(8);
      chk("glitch_period", period, GL ? 1530 : 1147);
      chk("glitch_strobes", strobes, 2);

      // silence: signal_lost exactly TO clocks after the last edge pulse
      tick(last_rise + 765 - cyc);
      sig_in = 1'b0;
      tick(last_rise + TO + 50 - cyc);
      chk("timeout_dist", lost_rise_cyc - (last_rise + 4), TO);
      chk("timeout_lost", signal_lost, 1);
      chk("timeout_period_held", period, GL ? 1530 : 1147);

      // averaging and floor
      first_rise();
      gap(1000); gap(1000); gap(1002); gap(1002);
      tick(8);
      chk("avg_1001", period, 1001);
      gap(1000); gap(1001); gap(1001); gap(1001);
      tick(8);
      chk("avg_floor_1000", period, 1000);

      // asynchronous reset mid-window
      gap(1000); gap(1000);
      tick(last_rise + 500 - cyc);
      sig_in = 1'b0;
      tick(20);
      #2 reset_n = 1'b0;
      #1;
      chk("midreset_period", period, 0);
      chk("midreset_lost", signal_lost, 1);
      chk("midreset_valid", period_valid, 0);
      tick(3);
      #2 reset_n = 1'b1;

      // clear coincident with an edge pulse
      first_rise();
      for (int i = 0; i < 4; i++) gap(1200);
      tick(8);
      chk("pre_clear_period", period, 1200);
      tick(last_rise + 600 - cyc);
      sig_in = 1'b0;
      tick(last_rise + 1200 - cyc);
      rise_now();
      tick(3);
      clear = 1'b1;
      clr_q.push_back(cyc + 1);
      tick(1);
      clear = 1'b0;
      sc = strobes;
      for (int i = 0; i < 4; i++) gap(1200);
      tick(8);
      chk("clear_no_strobe", strobes - sc, 0);
      chk("clear_lost", signal_lost, 1);
      gap(1200);
      tick(8);
      chk("clear_fifth_strobe", strobes - sc, 1);
      chk("clear_relock_lost", signal_lost, 0);

      // edge exactly at the timeout count is a valid sample
      for (int i = 0; i < 4; i++) gap(TO);
      tick(8);
      chk("edge_at_timeout_period", period, TO);
      chk("edge_at_timeout_lost", signal_lost, 0);
      gap(TO + 1);
      tick(8);
      chk("past_timeout_lost", signal_lost, 1);
      chk("past_timeout_period", period, TO);

      tick(10);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
